// File: rtl/seg7_sequence_reader.sv
// Receive-side checker for a 7-segment display bus: synchronizes and debounces the
// segment lines, decodes them back to BCD and verifies the digits follow the up/down count.
module seg7_sequence_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int ERR_W         = 8
) (
    input  logic             PIN_Y2,
    input  logic             SW0,
    input  logic [0:6]       segments,
    input  logic             SW17,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             step_pulse,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int RUN_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_BAD   = 2'b10
    } state_t;

    // Returns {legal, digit} for an active-high abcdefg pattern (a is the MSB).
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b1111110: return {1'b1, 4'd0};
            7'b0110000: return {1'b1, 4'd1};
            7'b1101101: return {1'b1, 4'd2};
            7'b1111001: return {1'b1, 4'd3};
            7'b0110011: return {1'b1, 4'd4};
            7'b1011011: return {1'b1, 4'd5};
            7'b1011111: return {1'b1, 4'd6};
            7'b1110000: return {1'b1, 4'd7};
            7'b1111111: return {1'b1, 4'd8};
            7'b1111011: return {1'b1, 4'd9};
            default:    return 5'b0_0000;
        endcase
    endfunction

    logic [6:0]       seg_raw;
    logic [6:0]       sync1_q, sync2_q, prev_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             changed, accept;
    logic [6:0]       pattern;
    logic [4:0]       dec;
    logic             legal;
    logic [3:0]       dec_digit, exp_digit;

    state_t           state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             pulse_q, pulse_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             err_inc;

    assign seg_raw   = segments;
    assign changed   = (sync2_q != prev_q);
    assign pattern   = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign dec       = decode_seg(pattern);
    assign legal     = dec[4];
    assign dec_digit = dec[3:0];

    always_comb begin
        run_d = run_q;
        if (changed) begin
            run_d = RUN_W'(1);
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    // Fires once per stable run: only on the cycle the count first arrives at the limit.
    assign accept = (run_d == RUN_MAX) && (changed || (run_q != RUN_MAX));

    always_ff @(posedge PIN_Y2) begin
        if (!SW0) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            run_q     <= '0;
            state_q   <= ST_IDLE;
            digit_q   <= '0;
            pulse_q   <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
        end else begin
            sync1_q   <= seg_raw;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            run_q     <= run_d;
            state_q   <= state_d;
            digit_q   <= digit_d;
            pulse_q   <= pulse_d;
            seq_err_q <= seq_err_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = legal ? ST_TRACK : ST_BAD;
        end
    end

    always_comb begin
        exp_digit = SW17 ? ((digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1)
                         : ((digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1);
        digit_d = digit_q;
        pulse_d = 1'b0;
        err_inc = 1'b0;
        if (accept) begin
            if (!legal) begin
                err_inc = (state_q != ST_BAD);
            end else begin
                digit_d = dec_digit;
                if (state_q == ST_TRACK && dec_digit != digit_q) begin
                    if (dec_digit == exp_digit) begin
                        pulse_d = !pulse_q;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
        end
        seq_err_d = seq_err_q | err_inc;
        err_d     = (err_inc && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    end

    assign digit       = digit_q;
    assign digit_valid = (state_q == ST_TRACK);
    assign step_pulse  = pulse_q;
    assign seq_err     = seq_err_q;
    assign err_count   = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_seg7_sequence_reader.sv
// Bench for seg7_sequence_reader: directed scenarios plus random segment traffic,
// every cycle compared against a behavioural model of the display checker.
module tb_seg7_sequence_reader;

    localparam int STABLE = 4;

    logic       PIN_Y2;
    logic       SW0;
    logic [0:6] segments;
    logic       SW17;

    logic [3:0] digit, digit2;
    logic       digit_valid, digit_valid2;
    logic       step_pulse, step_pulse2;
    logic       seq_err, seq_err2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic [1:0] state, state2;

    seg7_sequence_reader #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1), .ERR_W(8)) dut (
        .PIN_Y2(PIN_Y2), .SW0(SW0), .segments(segments), .SW17(SW17),
        .digit(digit), .digit_valid(digit_valid), .step_pulse(step_pulse),
        .seq_err(seq_err), .err_count(err_count), .state(state)
    );

    seg7_sequence_reader #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1), .ERR_W(2)) dut_sat (
        .PIN_Y2(PIN_Y2), .SW0(SW0), .segments(segments), .SW17(SW17),
        .digit(digit2), .digit_valid(digit_valid2), .step_pulse(step_pulse2),
        .seq_err(seq_err2), .err_count(err_count2), .state(state2)
    );

    initial PIN_Y2 = 1'b0;
    always #5 PIN_Y2 = ~PIN_Y2;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Active-high abcdefg shapes of the ten digits, a in the MSB.
    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // Reference model state
    logic [6:0] dly_q [$];
    logic [6:0] last_seen;
    int run_len;
    int m_state, m_digit, m_pulse, m_seq_err, m_err8, m_err2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] raw_of(input int d);
        logic [6:0] p;
        p = seg_tab[d];
        return ~p;
    endfunction

    task automatic model_reset();
        dly_q = '{7'h00, 7'h00};
        last_seen = 7'h00;
        run_len = 0;
        m_state = 0; m_digit = 0; m_pulse = 0; m_seq_err = 0; m_err8 = 0; m_err2 = 0;
    endtask

    // One rising edge of the reference: a value becomes visible to the filter two
    // edges after it is applied; a run of STABLE equal values is accepted once.
    task automatic model_edge();
        logic [6:0] seen, norm, cur_in;
        int old_run, d, exp_d;
        bit same, accept, legal, inc;
        if (!SW0) begin
            model_reset();
            return;
        end
        cur_in = segments;
        seen = dly_q.pop_front();
        dly_q.push_back(cur_in);
        same = (seen == last_seen);
        old_run = run_len;
        if (!same) run_len = 1;
        else if (run_len < STABLE) run_len++;
        accept = (run_len == STABLE) && !(same && old_run == STABLE);
        last_seen = seen;
        m_pulse = 0;
        inc = 0;
        if (accept) begin
            norm = ~seen;
            legal = 0;
            d = 0;
            for (int i = 0; i < 10; i++) begin
                if (seg_tab[i] == norm) begin
                    legal = 1;
                    d = i;
                end
            end
            if (!legal) begin
                if (m_state != 2) inc = 1;
                m_state = 2;
            end else begin
                if (m_state == 1 && d != m_digit) begin
                    exp_d = SW17 ? (m_digit + 1) % 10 : (m_digit + 9) % 10;
                    if (d == exp_d) m_pulse = 1;
                    else inc = 1;
                end
                m_digit = d;
                m_state = 1;
            end
        end
        if (inc) begin
            m_seq_err = 1;
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
        end
    endtask

    task automatic tick();
        @(posedge PIN_Y2);
        model_edge();
        #1;
        if (step_pulse) pulses++;
        chk("state", 32'(state), 32'(m_state));
        chk("digit", 32'(digit), 32'(m_digit));
        chk("digit_valid", 32'(digit_valid), 32'(m_state == 1));
        chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
        chk("seq_err", 32'(seq_err), 32'(m_seq_err));
        chk("err_count", 32'(err_count), 32'(m_err8));
        chk("err_count_w2", 32'(err_count2), 32'(m_err2));
        chk("state_w2", 32'(state2), 32'(m_state));
    endtask

    task automatic hold(input logic [6:0] raw, input int n);
        segments = raw;
        repeat (n) tick();
    endtask

    initial begin
        int r, d, n, err_snap;
        model_reset();
        SW0 = 1'b0;
        SW17 = 1'b1;
        segments = 7'h7F;

        // Reset, then digit 0 accepted exactly six cycles after it is applied
        repeat (2) tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);
        SW0 = 1'b1;
        hold(raw_of(0), 5);
        chk("latency_before", 32'(state), 32'd0);
        hold(raw_of(0), 1);
        chk("latency_state", 32'(state), 32'd1);
        chk("latency_digit", 32'(digit), 32'd0);
        hold(raw_of(0), 4);

        // Up count 0..9 and wrap to 0
        SW17 = 1'b1;
        pulses = 0;
        hold(raw_of(0), 8);
        for (int i = 1; i <= 10; i++) hold(raw_of(i % 10), 8);
        chk("up_pulses", 32'(pulses), 32'd10);
        chk("up_err", 32'(err_count), 32'd0);
        chk("up_seq_err", 32'(seq_err), 32'd0);

        // Down wrap 0 -> 9, then a skip 9 -> 7
        SW17 = 1'b0;
        pulses = 0;
        hold(raw_of(9), 8);
        chk("down_wrap_pulse", 32'(pulses), 32'd1);
        hold(raw_of(7), 8);
        chk("skip_err", 32'(err_count), 32'd1);
        chk("skip_seq_err", 32'(seq_err), 32'd1);
        chk("skip_digit", 32'(digit), 32'd7);
        chk("skip_pulses", 32'(pulses), 32'd1);

        // Short glitch to all-off is filtered out
        hold(raw_of(3), 8);
        err_snap = int'(err_count);
        hold(7'h7F, 3);
        hold(raw_of(3), 10);
        chk("glitch_err", 32'(err_count), 32'(err_snap));
        chk("glitch_digit", 32'(digit), 32'd3);
        chk("glitch_state", 32'(state), 32'd1);

        // Illegal patterns: one count on entering BAD, then resync on digit 5
        hold(7'h7F, 8);
        chk("bad_state", 32'(state), 32'd2);
        chk("bad_err", 32'(err_count), 32'(err_snap + 1));
        chk("bad_digit", 32'(digit), 32'd3);
        hold(7'b0101010, 8);
        chk("bad2_err", 32'(err_count), 32'(err_snap + 1));
        pulses = 0;
        hold(raw_of(5), 8);
        chk("resync_state", 32'(state), 32'd1);
        chk("resync_digit", 32'(digit), 32'd5);
        chk("resync_pulses", 32'(pulses), 32'd0);

        // Saturation of the 2-bit counter, then reset in the middle of a filter run
        for (int i = 0; i < 5; i++) begin
            hold(7'h7F, 8);
            hold(raw_of(i), 8);
        end
        chk("sat_err_w2", 32'(err_count2), 32'd3);
        segments = raw_of(8);
        tick();
        tick();
        SW0 = 1'b0;
        tick();
        chk("midreset_state", 32'(state), 32'd0);
        chk("midreset_err", 32'(err_count), 32'd0);
        chk("midreset_seq_err", 32'(seq_err), 32'd0);
        SW0 = 1'b1;

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 99));
            SW17 = 1'($urandom_range(0, 1));
            if (r < 3) begin
                SW0 = 1'b0;
                tick();
                SW0 = 1'b1;
            end else if (r < 15) begin
                n = int'($urandom_range(1, 8));
                hold(7'($urandom_range(0, 127)), n);
            end else begin
                if (r < 65) d = SW17 ? (m_digit + 1) % 10 : (m_digit + 9) % 10;
                else d = int'($urandom_range(0, 9));
                n = int'($urandom_range(1, 9));
                hold(raw_of(d), n);
            end
        end
        hold(segments, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
